// File: rtl/nco_freq_meas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : nco_freq_meas
// Times 2^CYCLES_LOG2 periods of a sampled tone and returns the equivalent
// 32-bit NCO phase increment, floor(2^(32+CYCLES_LOG2) / samples counted).
// Rev    : 1.0  initial release
// ============================================================================

module nco_freq_meas #(
    parameter int DATA_WIDTH  = 12,
    parameter int CYCLES_LOG2 = 4,
    parameter int HYST        = 64,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         meas_valid,
    output logic [31:0]                  meas_phase_inc,
    output logic [CNT_WIDTH-1:0]         meas_period,
    output logic                         timeout,
    output logic                         busy
);

    localparam int                            c_QW      = 33 + CYCLES_LOG2;
    localparam int                            c_IDX_W   = $clog2(c_QW);
    localparam logic [c_IDX_W-1:0]            c_IDX_TOP = c_IDX_W'(c_QW - 1);
    localparam logic [CYCLES_LOG2:0]          c_PER_TGT = (CYCLES_LOG2+1)'(1 << CYCLES_LOG2);
    localparam logic [CNT_WIDTH-1:0]          c_CNT_MAX = '1;
    localparam logic signed [DATA_WIDTH-1:0]  c_POS     = DATA_WIDTH'(HYST);
    localparam logic signed [DATA_WIDTH-1:0]  c_NEG     = DATA_WIDTH'(-HYST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_MEASURE = 2'd2,
        S_DIVIDE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_armed;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CYCLES_LOG2:0]   r_per;
    logic [CNT_WIDTH-1:0]   r_div;
    logic [CNT_WIDTH-1:0]   r_rem;
    logic [c_QW-2:0]        r_quo;
    logic [c_IDX_W-1:0]     r_idx;

    logic                   w_sample;
    logic                   w_rise;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [CYCLES_LOG2:0]   w_per_inc;
    logic                   w_start;
    logic                   w_meas_done;
    logic                   w_tmo;
    logic                   w_div_step;
    logic                   w_div_done;
    logic                   w_num_bit;
    logic [CNT_WIDTH:0]     w_rem_sh;
    logic                   w_ge;
    logic [CNT_WIDTH-1:0]   w_rem_next;
    logic [c_QW-1:0]        w_quo_next;
    logic                   w_sat;

    // The detector only listens while hunting for or timing crossings.
    assign w_sample  = enable && in_valid && (r_state == S_SYNC || r_state == S_MEASURE);
    assign w_rise    = w_sample && r_armed && (in_data >= c_POS);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_per_inc = r_per + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_armed <= 1'b0;
        end else if (w_sample) begin
            if (in_data <= c_NEG) begin
                r_armed <= 1'b1;
            end else if (in_data >= c_POS) begin
                r_armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_meas_done  = 1'b0;
        w_tmo        = 1'b0;
        w_div_step   = 1'b0;
        w_div_done   = 1'b0;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_SYNC;
                end
                S_SYNC: begin
                    if (w_rise) begin
                        w_start      = 1'b1;
                        w_state_next = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    // A finished measurement wins over a simultaneous saturation.
                    if (w_sample) begin
                        if (w_rise && (w_per_inc == c_PER_TGT)) begin
                            w_meas_done  = 1'b1;
                            w_state_next = S_DIVIDE;
                        end else if (w_cnt_inc == c_CNT_MAX) begin
                            w_tmo        = 1'b1;
                            w_state_next = S_SYNC;
                        end
                    end
                end
                S_DIVIDE: begin
                    w_div_step = 1'b1;
                    if (r_idx == '0) begin
                        w_div_done   = 1'b1;
                        w_state_next = S_SYNC;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Numerator is a single set bit, so it only feeds a 1 on the first step.
    assign w_num_bit  = (r_idx == c_IDX_TOP);
    assign w_rem_sh   = {r_rem, w_num_bit};
    assign w_ge       = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_next = w_ge ? CNT_WIDTH'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[CNT_WIDTH-1:0];
    assign w_quo_next = {r_quo, w_ge};
    assign w_sat      = |w_quo_next[c_QW-1:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_per <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_idx <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_per <= '0;
            end else if (r_state == S_MEASURE && w_sample) begin
                r_cnt <= w_cnt_inc;
                if (w_rise) begin
                    r_per <= w_per_inc;
                end
            end
            if (w_meas_done) begin
                r_div <= w_cnt_inc;
                r_rem <= '0;
                r_quo <= '0;
                r_idx <= c_IDX_TOP;
            end else if (w_div_step) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next[c_QW-2:0];
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid     <= 1'b0;
            meas_phase_inc <= '0;
            meas_period    <= '0;
            timeout        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            meas_valid <= w_div_done;
            timeout    <= w_tmo;
            busy       <= (w_state_next != S_IDLE);
            if (w_div_done) begin
                meas_phase_inc <= w_sat ? 32'hFFFF_FFFF : w_quo_next[31:0];
                meas_period    <= r_div;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nco_freq_meas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_nco_freq_meas
// Directed bench for nco_freq_meas with a spec-level result model.
// Rev    : 1.0  initial release
// ============================================================================

module tb_nco_freq_meas;

    localparam int c_CL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        enable_t;
    logic        in_valid;
    logic signed [11:0] in_data;

    logic        meas_valid, timeout, busy;
    logic [31:0] meas_phase_inc;
    logic [23:0] meas_period;
    logic        meas_valid_t, timeout_t, busy_t;
    logic [31:0] meas_phase_inc_t;
    logic [11:0] meas_period_t;

    always #5 clk = ~clk;

    nco_freq_meas dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .meas_valid(meas_valid), .meas_phase_inc(meas_phase_inc), .meas_period(meas_period),
        .timeout(timeout), .busy(busy)
    );

    nco_freq_meas #(.CNT_WIDTH(12)) dut_t (
        .clk(clk), .reset_n(reset_n), .enable(enable_t), .in_valid(in_valid), .in_data(in_data),
        .meas_valid(meas_valid_t), .meas_phase_inc(meas_phase_inc_t), .meas_period(meas_period_t),
        .timeout(timeout_t), .busy(busy_t)
    );

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_results = 0;
    longint      cyc       = 0;
    longint      result_cyc[$];
    logic [31:0] exp_phase = '0;
    logic [23:0] exp_period = '0;
    logic [31:0] held_phase = '0;
    logic [23:0] held_period = '0;
    bit          no_result = 1'b0;

    logic [31:0] gen_phase = '0;
    logic [31:0] gen_inc = '0;
    int          gen_mode = 2;
    bit          gen_tog = 1'b0;
    bit          gen_vph = 1'b0;
    bit          gen_nsign = 1'b0;
    logic signed [11:0] gen_fixed = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected result for an exactly periodic tone: period P = 2^32/inc samples.
    task automatic set_model(input logic [31:0] inc);
        logic [63:0] per;
        logic [63:0] ph;
        per = (64'h1_0000_0000 / {32'h0, inc}) << c_CL;
        ph  = (64'h1 << (32 + c_CL)) / per;
        exp_period = per[23:0];
        exp_phase  = (ph >= 64'h1_0000_0000) ? 32'hFFFF_FFFF : ph[31:0];
    endtask

    task automatic drive();
        case (gen_mode)
            0: begin
                if (gen_tog && gen_vph) begin
                    in_valid = 1'b0;
                    in_data  = 12'sh7FF;
                end else begin
                    in_valid  = 1'b1;
                    in_data   = gen_phase[31:20];
                    gen_phase = gen_phase + gen_inc;
                end
                gen_vph = gen_tog ? ~gen_vph : 1'b0;
            end
            1: begin
                in_valid  = 1'b1;
                in_data   = gen_nsign ? 12'sd40 : -12'sd40;
                gen_nsign = ~gen_nsign;
            end
            default: begin
                in_valid = 1'b1;
                in_data  = gen_fixed;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start(input logic [31:0] inc, input bit tog);
        gen_mode  = 0;
        gen_inc   = inc;
        gen_phase = 32'h8000_0000;
        gen_tog   = tog;
        gen_vph   = 1'b0;
        set_model(inc);
        tick();
        enable = 1'b1;
    endtask

    task automatic wait_result(input int limit, output int ticks);
        int start_n;
        start_n = n_results;
        ticks   = 0;
        while (n_results == start_n && ticks < limit) begin
            tick();
            ticks++;
        end
        check("wait_result", (n_results != start_n), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Every cycle: results must match the model, otherwise outputs must hold.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            held_phase  = '0;
            held_period = '0;
        end
        if (meas_valid) begin
            check("unexpected_result", no_result, 0);
            check("meas_period", meas_period, exp_period);
            check("meas_phase_inc", meas_phase_inc, exp_phase);
            held_phase  = exp_phase;
            held_period = exp_period;
            result_cyc.push_back(cyc);
            n_results++;
        end else begin
            check("hold_period", meas_period, held_period);
            check("hold_phase", meas_phase_inc, held_phase);
        end
        check("main_timeout", timeout, 0);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1;
        int t;
        int k;
        bit seen_valid_t;

        reset_n  = 1'b0;
        enable   = 1'b0;
        enable_t = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        check("rst_valid", meas_valid, 0);
        check("rst_phase", meas_phase_inc, 0);
        check("rst_period", meas_period, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_t_busy", busy_t, 0);
        check("rst_t_timeout", timeout_t, 0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", busy, 0);

        // Case 1: P = 256
        start(32'h0100_0000, 1'b0);
        tick();
        check("c1_busy", busy, 1);
        wait_result(5000, t1);
        t1 = t1 + 1;
        check("c1_latency", (t1 <= 17 * 256 + 37), 1);
        check("c1_period_lit", meas_period, 24'd4096);
        check("c1_phase_lit", meas_phase_inc, 32'h0100_0000);
        check("c1_pulse_width", meas_valid, 0);
        check("c1_resync_busy", busy, 1);
        if (t1 < 200 || t1 > 5000) t1 = 4267;
        enable = 1'b0;
        repeat (2) tick();

        // Case 2: in_valid gaps
        start(32'h0400_0000, 1'b1);
        wait_result(4000, t);
        check("c2_period_lit", meas_period, 24'd1024);
        check("c2_phase_lit", meas_phase_inc, 32'h0400_0000);
        enable = 1'b0;
        repeat (2) tick();

        // Case 4: abort mid-MEASURE, then mid-DIVIDE
        start(32'h0100_0000, 1'b0);
        repeat (t1 / 2) tick();
        check("c4_busy_meas", busy, 1);
        enable    = 1'b0;
        no_result = 1'b1;
        tick();
        check("c4_idle_meas", busy, 0);
        repeat (5) tick();
        start(32'h0100_0000, 1'b0);
        repeat (t1 - 20) tick();
        check("c4_busy_div", busy, 1);
        enable = 1'b0;
        tick();
        check("c4_idle_div", busy, 0);
        repeat (60) tick();
        check("c4_hold_period", meas_period, 24'd1024);
        check("c4_hold_phase", meas_phase_inc, 32'h0400_0000);
        no_result = 1'b0;
        start(32'h0100_0000, 1'b0);
        wait_result(5000, t);
        check("c4_period_lit", meas_period, 24'd4096);
        check("c4_phase_lit", meas_phase_inc, 32'h0100_0000);
        enable = 1'b0;
        repeat (2) tick();

        // Case 5: async reset mid-DIVIDE
        start(32'h0100_0000, 1'b0);
        repeat (t1 - 20) tick();
        reset_n = 1'b0;
        #1;
        check("c5_phase_zero", meas_phase_inc, 0);
        check("c5_period_zero", meas_period, 0);
        check("c5_busy_zero", busy, 0);
        check("c5_valid_zero", meas_valid, 0);
        enable = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        start(32'h0100_0000, 1'b0);
        wait_result(5000, t);
        check("c5_period_lit", meas_period, 24'd4096);
        check("c5_phase_lit", meas_phase_inc, 32'h0100_0000);
        enable = 1'b0;
        repeat (2) tick();

        // Case 3: noise below hysteresis, CNT_WIDTH = 12 instance
        gen_mode = 1;
        enable_t = 1'b1;
        seen_valid_t = 1'b0;
        repeat (3) tick();
        check("c3_busy_sync", busy_t, 1);
        for (int rep = 0; rep < 2; rep++) begin
            repeat (50) begin
                tick();
                if (timeout_t || meas_valid_t) seen_valid_t = 1'b1;
            end
            check("c3_no_early_pulse", seen_valid_t, 0);
            gen_mode  = 2;
            gen_fixed = -12'sd100;
            tick();
            gen_fixed = 12'sd100;
            tick();
            gen_mode = 1;
            k = 0;
            do begin
                tick();
                k++;
                if (meas_valid_t) seen_valid_t = 1'b1;
            end while (!timeout_t && k < 5000);
            check("c3_timeout_samples", k, 4096);
            tick();
            check("c3_timeout_pulse", timeout_t, 0);
            check("c3_resync_busy", busy_t, 1);
        end
        check("c3_no_result", seen_valid_t, 0);
        check("c3_period_t", meas_period_t, 0);
        enable_t = 1'b0;
        repeat (2) tick();

        // Case 6: back-to-back, P = 512
        start(32'h0080_0000, 1'b0);
        for (int r = 0; r < 3; r++) begin
            wait_result(10000, t);
        end
        check("c6_period_lit", meas_period, 24'd8192);
        check("c6_phase_lit", meas_phase_inc, 32'h0080_0000);
        if (result_cyc.size() >= 3) begin
            check("c6_gap_a", result_cyc[result_cyc.size()-1] - result_cyc[result_cyc.size()-2], 64'd8704);
            check("c6_gap_b", result_cyc[result_cyc.size()-2] - result_cyc[result_cyc.size()-3], 64'd8704);
        end else begin
            check("c6_result_count", result_cyc.size(), 3);
        end
        enable = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
